// File: rtl/system_core.sv
//==============================================================================
// system_core : GPIO nibble change reporter over UART TX, UART RX command port
//               driving GPIO outputs, LED toggling on each transmitted frame.
// Optional feature macro: GPIO_DEBOUNCE_EN (input debounce filter).
// Revision    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module system_core #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int UART_BAUD_RATE  = 115_200,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic       led,
  input  logic       uart_rxd,
  output logic       uart_txd,
  inout  wire  [7:0] gpio_io
);

  localparam int c_div   = CLK_FREQ / UART_BAUD_RATE;
  localparam int c_cnt_w = $clog2(c_div);
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_div - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'((c_div / 2) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Input path: synchronizer and change detection
  // ---------------------------------------------------------------------------
  logic [3:0] gin_s1_q, gin_s2_q;
  logic [3:0] prev_q, prev_d;
  logic       evt;
  logic [7:0] evt_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gin_s1_q <= 4'h0;
      gin_s2_q <= 4'h0;
      prev_q   <= 4'h0;
    end else begin
      gin_s1_q <= gpio_io[3:0];
      gin_s2_q <= gin_s1_q;
      prev_q   <= prev_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int c_db_w = $clog2(DEBOUNCE_CYCLES + 1);
  logic [c_db_w-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    evt      = 1'b0;
    prev_d   = prev_q;
    db_cnt_d = '0;
    if (gin_s2_q != prev_q) begin
      if (db_cnt_q == c_db_w'(DEBOUNCE_CYCLES - 1)) begin
        evt    = 1'b1;
        prev_d = gin_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) db_cnt_q <= '0;
    else     db_cnt_q <= db_cnt_d;
  end
`else
  always_comb begin
    evt    = (gin_s2_q != prev_q);
    prev_d = gin_s2_q;
  end
`endif

  assign evt_byte = {4'hA, gin_s2_q};

  // ---------------------------------------------------------------------------
  // UART transmitter with one-deep overwrite pending slot
  // ---------------------------------------------------------------------------
  uart_state_e        tx_state_q, tx_state_d;
  logic [c_cnt_w-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]         tx_bit_q, tx_bit_d;
  logic [7:0]         tx_sh_q, tx_sh_d;
  logic               txd_q, txd_d;
  logic               pend_v_q, pend_v_d;
  logic [7:0]         pend_q, pend_d;
  logic               led_q, led_d;
  logic               tx_stop_end;

  assign tx_stop_end = (tx_state_q == S_STOP) && (tx_cnt_q == c_bit_last);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    pend_v_d   = pend_v_q;
    pend_d     = pend_q;
    led_d      = led_q;
    case (tx_state_q)
      S_IDLE: begin
        if (evt) begin
          tx_state_d = S_START;
          tx_sh_d    = evt_byte;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          led_d      = ~led_q;
        end
      end
      S_START: begin
        if (tx_cnt_q == c_bit_last) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
          txd_d      = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == c_bit_last) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == c_bit_last) begin
          tx_cnt_d = '0;
          // An event landing on the final stop cycle is newer than the slot.
          if (evt || pend_v_q) begin
            tx_state_d = S_START;
            tx_sh_d    = evt ? evt_byte : pend_q;
            txd_d      = 1'b0;
            led_d      = ~led_q;
            pend_v_d   = 1'b0;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (evt && (tx_state_q != S_IDLE) && !tx_stop_end) begin
      pend_v_d = 1'b1;
      pend_d   = evt_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'h00;
      txd_q      <= 1'b1;
      pend_v_q   <= 1'b0;
      pend_q     <= 8'h00;
      led_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      pend_v_q   <= pend_v_d;
      pend_q     <= pend_d;
      led_q      <= led_d;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receiver and GPIO output command decode
  // ---------------------------------------------------------------------------
  logic               rx_s1_q, rx_s2_q, rx_s3_q;
  uart_state_e        rx_state_q, rx_state_d;
  logic [c_cnt_w-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]         rx_bit_q, rx_bit_d;
  logic [7:0]         rx_sh_q, rx_sh_d;
  logic [3:0]         gpo_q, gpo_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    gpo_d      = gpo_q;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == c_half_last) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == c_bit_last) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == c_bit_last) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rx_s2_q && (rx_sh_q[7:4] == 4'h5)) gpo_d = rx_sh_q[3:0];
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      gpo_q      <= 4'h0;
    end else begin
      rx_s1_q    <= uart_rxd;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      gpo_q      <= gpo_d;
    end
  end

  assign led          = led_q;
  assign uart_txd     = txd_q;
  assign gpio_io[7:4] = gpo_q;
  assign gpio_io[3:0] = 4'bzzzz;

endmodule

`default_nettype wire

// File: tb/tb_system_core.sv
//==============================================================================
// tb_system_core : scoreboard bench for system_core (UART TX frame decoder,
//                  RX command driver, reset behaviour).
// Revision       : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_system_core;

  localparam int DIV = 43;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       led;
  logic       uart_txd;
  wire  [7:0] gpio_io;
  logic [3:0] gin = 4'h0;

  assign gpio_io[3:0] = gin;

  always #10 clk = ~clk;

  system_core #(
    .CLK_FREQ       (50_000_000),
    .UART_BAUD_RATE (1_152_000),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .led     (led),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd),
    .gpio_io (gpio_io)
  );

  int         n_checks   = 0;
  int         n_errors   = 0;
  int         cyc        = 0;
  int         n_frames   = 0;
  int         rst_epoch  = 0;
  int         last_start = 0;
  int         prev_start = 0;
  bit         mon_en     = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;
  always @(posedge rst) rst_epoch++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (n_frames < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frame_count", n_frames, n);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (DIV) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  // Frame decoder: samples each bit at its centre, discards frames cut by reset.
  initial begin : mon
    logic [7:0] b;
    logic       sb, pb;
    int         ep, st;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && uart_txd === 1'b0) begin
        ep = rst_epoch;
        st = cyc;
        repeat (DIV / 2) @(negedge clk);
        sb = uart_txd;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (DIV) @(negedge clk);
        pb = uart_txd;
        if (ep == rst_epoch && !rst) begin
          n_frames++;
          prev_start = last_start;
          last_start = st;
          check("tx_start_bit", sb, 1'b0);
          check("tx_stop_bit", pb, 1'b1);
          if (exp_q.size() > 0) check("tx_byte", b, exp_q.pop_front());
          else                  check("tx_unexpected_frame", exp_q.size(), 1);
        end
      end
    end
  end

  initial begin : main
    int k;
    #5 rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_led", led, 1'b0);
    check("rst_gpo", gpio_io[7:4], 4'h0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    // Single input change
    exp_q.push_back(8'hAA);
    gin = 4'hA;
    k = 0;
    while (uart_txd !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("tx_latency_le4", (k <= 4), 1'b1);
    check("led_first_frame", led, 1'b1);
    wait_frames(1, 600);
    repeat (30) @(negedge clk);

    // Several changes while a frame is in flight: only the newest survives
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hAF);
    gin = 4'h0;
    repeat (100) @(negedge clk);
    gin = 4'h5;
    repeat (100) @(negedge clk);
    gin = 4'hF;
    wait_frames(3, 1200);
    repeat (500) @(negedge clk);
    check("busy_no_extra", n_frames, 3);
    check("busy_gap", last_start - prev_start, 10 * DIV);
    check("led_two_toggles", led, 1'b1);

    // RX commands
    send_rx(8'h5C, 1'b1);
    check("rx_cmd_5C", gpio_io[7:4], 4'hC);
    send_rx(8'h3C, 1'b1);
    check("rx_ignore_3C", gpio_io[7:4], 4'hC);
    send_rx(8'h53, 1'b0);
    check("rx_frame_err", gpio_io[7:4], 4'hC);
    uart_rxd = 1'b0;
    repeat (5) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("rx_glitch", gpio_io[7:4], 4'hC);
    send_rx(8'h51, 1'b1);
    check("rx_cmd_51", gpio_io[7:4], 4'h1);

    // RX command and input event together
    exp_q.push_back(8'hA3);
    gin = 4'h3;
    send_rx(8'h57, 1'b1);
    check("rx_cmd_57_concurrent", gpio_io[7:4], 4'h7);
    wait_frames(4, 600);
    repeat (50) @(negedge clk);

    // Reset in the middle of a frame
    gin = 4'h0;
    k = 0;
    while (uart_txd !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("pre_rst_frame_started", uart_txd, 1'b0);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_txd", uart_txd, 1'b1);
    check("rst_mid_led", led, 1'b0);
    check("rst_mid_gpo", gpio_io[7:4], 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (700) @(negedge clk);
    check("no_frame_after_rst", n_frames, 4);
    check("txd_idle_after_rst", uart_txd, 1'b1);
    exp_q.push_back(8'hA6);
    gin = 4'h6;
    wait_frames(5, 600);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
